// File: rtl/bus_pkg.sv
// Shared bus definitions for the master-side blocks and the two-master arbiter:
// widths, burst constants, arbiter state encoding and the captured request record.
package bus_pkg;

  localparam int LEN_W  = 3;
  localparam int MASK_W = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic [LEN_W-1:0] LEN_SINGLE = 3'd1;
  localparam logic [LEN_W-1:0] LEN_LINE   = 3'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DATA  = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [LEN_W-1:0]  len;
    logic [MASK_W-1:0] mask;
    logic [ADDR_W-1:0] addr;
    logic              we;
  } req_fields_t;

  // A zero length means a single beat; anything past a line is clamped to a line.
  function automatic logic [LEN_W-1:0] norm_len(input logic [LEN_W-1:0] len);
    logic [LEN_W-1:0] res;
    if (len == 3'd0) begin
      res = LEN_SINGLE;
    end else if (len > LEN_LINE) begin
      res = LEN_LINE;
    end else begin
      res = len;
    end
    return res;
  endfunction

endpackage

// File: rtl/req_latch.sv
// Per-master request capture: one pending bit, the latched request fields and
// a drop strobe for pulses that arrive while the master is pending or owning.
module req_latch
  import bus_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  input  req_fields_t req_i,
  input  logic        owned_i,
  input  logic        take_i,
  output logic        pend_o,
  output req_fields_t fields_o,
  output logic        drop_o
);

  logic        pend_q, pend_d;
  req_fields_t fields_q, fields_d;

  // Capture, clear-on-grant and overflow detection.
  always_comb begin
    pend_d   = pend_q;
    fields_d = fields_q;
    drop_o   = 1'b0;
    if (take_i) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end
    if (req_valid_i) begin
      if (!pend_q && !owned_i) begin
        pend_d        = 1'b1;
        fields_d      = req_i;
        fields_d.len  = norm_len(req_i.len);
      end else begin
        drop_o = 1'b1;
      end
    end else begin
      drop_o = 1'b0;
    end
  end

  // Request state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q   <= 1'b0;
      fields_q <= '0;
    end else begin
      pend_q   <= pend_d;
      fields_q <= fields_d;
    end
  end

  assign pend_o   = pend_q;
  assign fields_o = fields_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter for the shared memory/peripheral request port: latches
// request pulses, grants one master per transaction and routes its data beats.
module mem_arbiter
  import bus_pkg::*;
#(
  parameter int RR = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_req_valid,
  input  logic [LEN_W-1:0]  m0_req_len,
  input  logic [MASK_W-1:0] m0_req_mask,
  input  logic [ADDR_W-1:0] m0_req_addr,
  input  logic              m0_req_we,
  output logic              m0_req_ready,
  input  logic              m0_dout_valid,
  input  logic [DATA_W-1:0] m0_dout,
  output logic              m0_din_valid,
  output logic [DATA_W-1:0] m0_din,
  input  logic              m0_din_ack,
  input  logic              m1_req_valid,
  input  logic [LEN_W-1:0]  m1_req_len,
  input  logic [MASK_W-1:0] m1_req_mask,
  input  logic [ADDR_W-1:0] m1_req_addr,
  input  logic              m1_req_we,
  output logic              m1_req_ready,
  input  logic              m1_dout_valid,
  input  logic [DATA_W-1:0] m1_dout,
  output logic              m1_din_valid,
  output logic [DATA_W-1:0] m1_din,
  input  logic              m1_din_ack,
  output logic              s_req_valid,
  output logic [LEN_W-1:0]  s_req_len,
  output logic [MASK_W-1:0] s_req_mask,
  output logic [ADDR_W-1:0] s_req_addr,
  output logic              s_req_we,
  input  logic              s_req_ready,
  output logic              s_dout_valid,
  output logic [DATA_W-1:0] s_dout,
  input  logic              s_din_valid,
  input  logic [DATA_W-1:0] s_din,
  output logic              s_din_ack,
  output logic [1:0]        grant,
  output logic              ovf
);

  arb_state_e       state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             last_q, last_d;
  logic [LEN_W-1:0] beats_q, beats_d;
  req_fields_t      s_req_q, s_req_d;
  logic             s_req_valid_q, s_req_valid_d;
  logic             ovf_q, ovf_d;

  req_fields_t m0_req_s, m1_req_s, fields0_s, fields1_s, win_fields_s;
  logic        pend0_s, pend1_s, drop0_s, drop1_s, take0_s, take1_s;
  logic        win1_s, beat_s, rd_s, wr_s;

  assign m0_req_s = '{len: m0_req_len, mask: m0_req_mask, addr: m0_req_addr, we: m0_req_we};
  assign m1_req_s = '{len: m1_req_len, mask: m1_req_mask, addr: m1_req_addr, we: m1_req_we};

  req_latch u_latch0 (
    .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(m0_req_valid), .req_i(m0_req_s),
    .owned_i(grant_q[0]), .take_i(take0_s), .pend_o(pend0_s), .fields_o(fields0_s),
    .drop_o(drop0_s)
  );

  req_latch u_latch1 (
    .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(m1_req_valid), .req_i(m1_req_s),
    .owned_i(grant_q[1]), .take_i(take1_s), .pend_o(pend1_s), .fields_o(fields1_s),
    .drop_o(drop1_s)
  );

  // Arbitration, issue and beat counting. last_q = 1 means M1 was granted last.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_d        = last_q;
    beats_d       = beats_q;
    s_req_d       = s_req_q;
    s_req_valid_d = 1'b0;
    take0_s       = 1'b0;
    take1_s       = 1'b0;
    win1_s        = pend1_s && (!pend0_s || ((RR != 0) && !last_q));
    win_fields_s  = win1_s ? fields1_s : fields0_s;
    ovf_d         = ovf_q | drop0_s | drop1_s;
    case (state_q)
      IDLE: begin
        if (pend0_s || pend1_s) begin
          take0_s       = !win1_s;
          take1_s       = win1_s;
          grant_d       = win1_s ? 2'b10 : 2'b01;
          s_req_d       = win_fields_s;
          beats_d       = win_fields_s.len;
          s_req_valid_d = 1'b1;
          state_d       = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = DATA;
      end
      DATA: begin
        if (beat_s) begin
          beats_d = beats_q - 3'd1;
          if (beats_q == 3'd1) begin
            state_d = IDLE;
            grant_d = 2'b00;
            last_d  = grant_q[1];
          end else begin
            state_d = DATA;
          end
        end else begin
          beats_d = beats_q;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  // Beat routing between the slave and the current owner; non-owners see zeros.
  always_comb begin
    rd_s         = (state_q == DATA) && !s_req_q.we;
    wr_s         = (state_q == DATA) && s_req_q.we;
    s_din_ack    = 1'b0;
    s_dout_valid = 1'b0;
    s_dout       = '0;
    m0_din_valid = 1'b0;
    m0_din       = '0;
    m1_din_valid = 1'b0;
    m1_din       = '0;
    m0_req_ready = 1'b0;
    m1_req_ready = 1'b0;
    if (rd_s) begin
      s_din_ack    = grant_q[1] ? m1_din_ack : m0_din_ack;
      m0_din_valid = grant_q[0] & s_din_valid;
      m0_din       = grant_q[0] ? s_din : '0;
      m1_din_valid = grant_q[1] & s_din_valid;
      m1_din       = grant_q[1] ? s_din : '0;
    end else if (wr_s) begin
      s_dout_valid = grant_q[1] ? m1_dout_valid : m0_dout_valid;
      s_dout       = grant_q[1] ? m1_dout : m0_dout;
      m0_req_ready = grant_q[0] & s_req_ready;
      m1_req_ready = grant_q[1] & s_req_ready;
    end else begin
      s_din_ack = 1'b0;
    end
    beat_s = s_din_ack | s_dout_valid;
  end

  // Arbiter state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      grant_q       <= 2'b00;
      last_q        <= 1'b1;
      beats_q       <= 3'd0;
      s_req_q       <= '0;
      s_req_valid_q <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_q        <= last_d;
      beats_q       <= beats_d;
      s_req_q       <= s_req_d;
      s_req_valid_q <= s_req_valid_d;
      ovf_q         <= ovf_d;
    end
  end

  assign s_req_valid = s_req_valid_q;
  assign s_req_len   = s_req_q.len;
  assign s_req_mask  = s_req_q.mask;
  assign s_req_addr  = s_req_q.addr;
  assign s_req_we    = s_req_q.we;
  assign grant       = grant_q;
  assign ovf         = ovf_q;

endmodule
